samp_phase_ctrl: RTL

- Sequencer for the analog sampling switch (`vin`→`vout` transmission gate driven by complementary `clk`/`clk_b`).
- Per conversion it:
  - accepts a start request;
  - closes the switch for a programmable track window;
  - opens it and waits a programmable settle/dead time;
  - pulses conversion start to the SAR logic;
  - waits for conversion done, then reports done.
- Sits between the ADC top-level sequencer and the switch black box.
- All outputs are registered so the analog drive is glitch-free.

---
 rtl/samp_ctrl_pkg.sv | 27 ++
 rtl/samp_phase_drv.sv | 49 ++++
 rtl/samp_phase_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/samp_ctrl_pkg.sv
// Shared types and constants for the sampling-switch phase controller.
// Build option: define SAMPCTRL_BBM_EN for break-before-make skew on sw_clk/sw_clk_b.
package samp_ctrl_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int SCNT_W_DEF = 16;

  // Idle (switch open) drive levels
  localparam logic SW_OPEN   = 1'b0;
  localparam logic SW_OPEN_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    TRACK,
    DEAD,
    CONV,
    WAIT
  } state_t;

  // Extra skew cycles on each switch edge
`ifdef SAMPCTRL_BBM_EN
  localparam int BBM_SK = 1;
`else
  localparam int BBM_SK = 0;
`endif

endpackage

// File: rtl/samp_phase_drv.sv
// Output register stage for the sampling switch gate drive.
// Ports: clk, rst, i_close_nxt (close request for next cycle) -> o_sw_clk, o_sw_clk_b.
// With SAMPCTRL_BBM_EN both drives go low for one cycle around every switch edge.
module samp_phase_drv
  import samp_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_close_nxt,
  output logic o_sw_clk,
  output logic o_sw_clk_b
);

  logic r_sw;
  logic r_sw_b;

`ifdef SAMPCTRL_BBM_EN
  // r_close is the request delayed by one cycle. sw_clk needs the
  // request for two cycles (rises late), sw_clk_b drops on the first
  // and recovers only after both are gone (rises late on open).
  logic r_close;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_close <= 1'b0;
      r_sw    <= SW_OPEN;
      r_sw_b  <= SW_OPEN_B;
    end else begin
      r_close <= i_close_nxt;
      r_sw    <= i_close_nxt & r_close;
      r_sw_b  <= ~(i_close_nxt | r_close);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw   <= SW_OPEN;
      r_sw_b <= SW_OPEN_B;
    end else begin
      r_sw   <= i_close_nxt;
      r_sw_b <= ~i_close_nxt;
    end
  end
`endif

  assign o_sw_clk   = r_sw;
  assign o_sw_clk_b = r_sw_b;

endmodule

// File: rtl/samp_phase_ctrl.sv
// Sampling switch sequencer: track, dead time, conversion start, wait for done.
// Ports: clk/rst, start/ready handshake, cfg_track/cfg_dead, sw_clk/sw_clk_b
// switch drive, conv_start/conv_done SAR handshake, busy, done, sample_cnt.
// Build option: SAMPCTRL_BBM_EN adds break-before-make skew (see samp_phase_drv).
module samp_phase_ctrl
  import samp_ctrl_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SCNT_W = SCNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ready,
  input  logic [CNT_W-1:0]  cfg_track,
  input  logic [CNT_W-1:0]  cfg_dead,
  output logic              sw_clk,
  output logic              sw_clk_b,
  output logic              conv_start,
  input  logic              conv_done,
  output logic              busy,
  output logic              done,
  output logic [SCNT_W-1:0] sample_cnt
);

  // One extra bit: with skew the track load can reach 2^CNT_W
  localparam int LW = CNT_W + 1;

  state_t            r_state;
  logic [LW-1:0]     r_cnt;
  logic [CNT_W-1:0]  r_dead;
  logic              r_conv_start;
  logic              r_done;
  logic              r_ready;
  logic              r_busy;
  logic [SCNT_W-1:0] r_sample_cnt;

  logic              w_accept;
  logic              w_close_nxt;
  logic [CNT_W-1:0]  w_trk_eff;
  logic [LW-1:0]     w_trk_load;

  assign w_accept = start && (r_state == IDLE);

  assign w_trk_eff = (cfg_track == '0) ?
                     {{(CNT_W-1){1'b0}}, 1'b1} : cfg_track;

  // TRACK lasts trk cycles, plus one skew cycle on each
  // side when break-before-make is built in.
  assign w_trk_load = {1'b0, w_trk_eff} - LW'(1)
                    + LW'(2 * BBM_SK);

  // Switch requested closed in the next cycle. The last
  // BBM_SK counts of TRACK are the open-skew cycle.
  assign w_close_nxt = w_accept ||
                       ((r_state == TRACK) &&
                        (r_cnt > LW'(BBM_SK)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_dead       <= '0;
      r_conv_start <= 1'b0;
      r_done       <= 1'b0;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_sample_cnt <= '0;
    end else begin
      r_conv_start <= 1'b0;
      r_done       <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt   <= w_trk_load;
            r_dead  <= cfg_dead;
            r_state <= TRACK;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        TRACK: begin
          if (r_cnt == '0) begin
            if (r_dead != '0) begin
              r_cnt   <= {1'b0, r_dead} - LW'(1);
              r_state <= DEAD;
            end else begin
              r_state      <= CONV;
              r_conv_start <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - LW'(1);
          end
        end
        DEAD: begin
          if (r_cnt == '0) begin
            r_state      <= CONV;
            r_conv_start <= 1'b1;
          end else begin
            r_cnt <= r_cnt - LW'(1);
          end
        end
        CONV: begin
          // conv_done is deliberately not looked at here
          r_state <= WAIT;
        end
        WAIT: begin
          if (conv_done) begin
            r_state      <= IDLE;
            r_done       <= 1'b1;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_sample_cnt <= r_sample_cnt + SCNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  samp_phase_drv u_drv (
    .clk         (clk),
    .rst         (rst),
    .i_close_nxt (w_close_nxt),
    .o_sw_clk    (sw_clk),
    .o_sw_clk_b  (sw_clk_b)
  );

  assign ready      = r_ready;
  assign busy       = r_busy;
  assign conv_start = r_conv_start;
  assign done       = r_done;
  assign sample_cnt = r_sample_cnt;

endmodule
